clock_divider_multi: RTL and testbench

Parametrised multi-channel clock/tick generator with a programmable divisor per channel. Each channel divides the board clock (MAX10_CLK1_50, 50 MHz) by a runtime half-period value. Each channel produces two outputs: a one-cycle tick and a 50 %-duty derived clock level. Channels can be gated individually, and a common sync pulse re-aligns all channels. The block sits between the board clock input and the LED/timebase consumers, replacing per-rate counter/toggle pairs with hard-wired constants.

---
 rtl/clock_div_pkg.sv | 13 +
 rtl/clock_divider_channel.sv | 64 ++++++
 rtl/clock_divider_multi.sv | 32 +++
 tb/tb_clock_divider_multi.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/clock_div_pkg.sv
// Shared widths and common half-period constants for the multi-channel clock divider.
// All constants assume the 50 MHz board clock.
package clock_div_pkg;

    localparam int DIV_W = 28;

    typedef logic [DIV_W-1:0] div_t;

    localparam div_t HP_10HZ  = div_t'(2_500_000);
    localparam div_t HP_1HZ   = div_t'(25_000_000);
    localparam div_t HP_0_1HZ = div_t'(250_000_000);

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counts enabled cycles up to a shadowed half-period K,
// emitting a one-cycle tick and toggling a 50 % level on each rollover.
module clock_divider_channel
    import clock_div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_sync,
    input  logic         i_en,
    input  logic [W-1:0] i_half_period,
    output logic         o_tick,
    output logic         o_clk
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] k_act_q, k_act_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;

    always_comb begin
        cnt_d   = cnt_q;
        k_act_d = k_act_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        if (i_sync) begin
            cnt_d   = '0;
            clk_d   = 1'b0;
            k_act_d = i_half_period;
        end else if (k_act_q == '0) begin
            // Halted: keep reloading so a nonzero divisor starts us next cycle.
            cnt_d   = '0;
            k_act_d = i_half_period;
        end else if (i_en) begin
            if (cnt_q == k_act_q - 1'b1) begin
                cnt_d   = '0;
                tick_d  = 1'b1;
                clk_d   = ~clk_q;
                k_act_d = i_half_period;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q   <= '0;
            k_act_q <= i_half_period;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            k_act_q <= k_act_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign o_tick = tick_q;
    assign o_clk  = clk_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel tick/clock-level generator: one independent divider per channel,
// sharing only reset and the phase-align sync.
module clock_divider_multi
    import clock_div_pkg::*;
#(
    parameter int N_CH = 3,
    parameter int W    = DIV_W
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N_CH-1:0]        i_en,
    input  logic                   i_sync,
    input  logic [N_CH-1:0][W-1:0] i_half_period,
    output logic [N_CH-1:0]        o_tick,
    output logic [N_CH-1:0]        o_clk
);

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        clock_divider_channel #(
            .W (W)
        ) u_ch (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_sync        (i_sync),
            .i_en          (i_en[ch]),
            .i_half_period (i_half_period[ch]),
            .o_tick        (o_tick[ch]),
            .o_clk         (o_clk[ch])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural per-channel model.
module tb_clock_divider_multi;

    localparam int N_CH = 3;
    localparam int W    = 28;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        en;
    logic                   sync;
    logic [N_CH-1:0][W-1:0] hp;
    logic [N_CH-1:0]        o_tick;
    logic [N_CH-1:0]        o_clk;

    int checks = 0;
    int errors = 0;

    // Model state: divisor in force, enabled cycles elapsed in the current half-period,
    // the derived level and the tick for the cycle just completed.
    int k_m  [N_CH];
    int el_m [N_CH];
    bit lvl_m[N_CH];
    bit tk_m [N_CH];

    clock_divider_multi #(.N_CH(N_CH), .W(W)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_en          (en),
        .i_sync        (sync),
        .i_half_period (hp),
        .o_tick        (o_tick),
        .o_clk         (o_clk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A half-period lasts K enabled cycles; restart/realign discards progress.
    task automatic model_edge();
        for (int c = 0; c < N_CH; c++) begin
            tk_m[c] = 1'b0;
            if (rst || sync) begin
                el_m[c] = 0; lvl_m[c] = 1'b0; k_m[c] = int'(hp[c]);
            end else if (k_m[c] == 0) begin
                el_m[c] = 0; k_m[c] = int'(hp[c]);
            end else if (en[c]) begin
                el_m[c] = el_m[c] + 1;
                if (el_m[c] >= k_m[c]) begin
                    el_m[c] = 0; tk_m[c] = 1'b1; lvl_m[c] = !lvl_m[c]; k_m[c] = int'(hp[c]);
                end
            end
        end
    endtask

    task automatic step();
        logic [N_CH-1:0] et, ec;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < N_CH; c++) begin
            et[c] = tk_m[c];
            ec[c] = lvl_m[c];
        end
        chk("tick", 32'(o_tick), 32'(et));
        chk("clk",  32'(o_clk),  32'(ec));
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!o_tick[ch] && n < max);
        if (!o_tick[ch]) chk("tick_timeout", 32'(n), 32'(max + 1));
    endtask

    initial begin
        int n;
        int cnt[N_CH];
        logic [N_CH-1:0] clk_hold;
        rst = 1'b0; sync = 1'b0; en = '0;
        hp[0] = 28'd5; hp[1] = 28'd3; hp[2] = 28'd1;

        // Reset state and basic divide over a 30-cycle window.
        do_reset();
        chk("rst_tick", 32'(o_tick), 32'd0);
        chk("rst_clk",  32'(o_clk),  32'd0);
        en = '1;
        cnt = '{0, 0, 0};
        for (int i = 0; i < 30; i++) begin
            step();
            for (int c = 0; c < N_CH; c++) cnt[c] += int'(o_tick[c]);
        end
        chk("basic_cnt0", 32'(cnt[0]), 32'd6);
        chk("basic_cnt1", 32'(cnt[1]), 32'd10);
        chk("basic_cnt2", 32'(cnt[2]), 32'd30);

        // Divisor change mid-period: current period finishes, then the new one applies.
        hp[0] = 28'd5;
        do_reset();
        step();
        hp[0] = 28'd2;
        wait_tick(0, 20, n); chk("chg_first", 32'(n), 32'd4);
        wait_tick(0, 20, n); chk("chg_next",  32'(n), 32'd2);
        wait_tick(0, 20, n); chk("chg_next2", 32'(n), 32'd2);

        // Enable gating: 3-cycle pause at cnt=2 delays the tick by 3.
        hp = {28'd4, 28'd4, 28'd4};
        do_reset();
        step(); step();
        en[0] = 1'b0;
        clk_hold = o_clk;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gate_notick", 32'(o_tick[0]), 32'd0);
            chk("gate_hold",   32'(o_clk[0]),  32'(clk_hold[0]));
        end
        en[0] = 1'b1;
        wait_tick(0, 20, n); chk("gate_resume", 32'(n), 32'd2);

        // Sync alignment after staggered enables.
        do_reset();
        en = 3'b001; step();
        en = 3'b011; step();
        en = 3'b111; step(); step();
        sync = 1'b1; step(); sync = 1'b0;
        chk("sync_clk",  32'(o_clk),  32'd0);
        chk("sync_tick", 32'(o_tick), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("sync_tick_eq", 32'(o_tick == 3'b000 || o_tick == 3'b111), 32'd1);
            chk("sync_clk_eq",  32'(o_clk  == 3'b000 || o_clk  == 3'b111), 32'd1);
        end

        // Halt and restart on ch1.
        hp[1] = 28'd0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_tick", 32'(o_tick[1]), 32'd0);
        end
        hp[1] = 28'd3;
        wait_tick(1, 20, n); chk("halt_restart", 32'(n), 32'd4);

        // Reset landing on the rollover cycle.
        hp = {28'd4, 28'd4, 28'd4};
        do_reset();
        step(); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_roll_tick", 32'(o_tick), 32'd0);
        chk("rst_roll_clk",  32'(o_clk),  32'd0);
        wait_tick(0, 20, n); chk("rst_roll_restart", 32'(n), 32'd4);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 9) == 0) hp[c] = W'($urandom_range(0, 6));
                en[c] = ($urandom_range(0, 3) != 0);
            end
            sync = ($urandom_range(0, 39) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0; sync = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
